// File: rtl/race_kill_ctrl.sv
// Launch/join controller for N parallel engines: join-any kills the losers, join-all waits for all.
// Optional watchdog on the RUN phase is built only when RACE_TIMEOUT_EN is defined.
module race_kill_ctrl #(
   parameter int unsigned N           = 3,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   output logic                 busy,
   output logic [N-1:0]         eng_start,
   input  logic [N-1:0]         eng_done,
   output logic [N-1:0]         eng_kill,
   input  logic [N-1:0]         eng_idle,
   output logic                 done,
   output logic [$clog2(N)-1:0] winner,
   output logic [N-1:0]         finished_mask,
   output logic [N-1:0]         killed_mask,
   output logic                 timeout
);

   localparam int unsigned WW = $clog2(N);

   // Reject configurations the masks and watchdog are not sized for.
   if (N < 2 || N > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("race_kill_ctrl: unsupported N or TIMEOUT_CYC");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_KILL   = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    active_q, active_d;
   logic            mode_q, mode_d;
   logic            seen_q, seen_d;
   logic [N-1:0]    fin_d, kil_d;
   logic [WW-1:0]   win_d;
   logic            to_d;
   logic [N-1:0]    hit;
   logic [N-1:0]    idle_hit;
   logic            busy_d, done_d;
   logic [N-1:0]    eng_start_d, eng_kill_d;

   // Lowest set index; simultaneous finishers resolve to the smallest engine number.
   function automatic logic [WW-1:0] lowest_idx(input logic [N-1:0] v);
      logic [WW-1:0] r;
      r = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (v[i]) r = WW'(i);
      end
      return r;
   endfunction

`ifdef RACE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q;
   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      mode_d   = mode_q;
      seen_d   = seen_q;
      fin_d    = finished_mask;
      kil_d    = killed_mask;
      win_d    = winner;
      to_d     = 1'b0;
      hit      = eng_done & active_q;
      idle_hit = '0;
`ifdef RACE_TIMEOUT_EN
      to_d     = to_q;
      cnt_d    = cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               fin_d   = '0;
               kil_d   = '0;
               win_d   = '0;
               seen_d  = 1'b0;
               to_d    = 1'b0;
`ifdef RACE_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            active_d = '1;
            state_d  = S_RUN;
         end

         S_RUN: begin
            fin_d    = finished_mask | hit;
            active_d = active_q & ~hit;
            if (hit != '0 && !seen_q) begin
               seen_d = 1'b1;
               win_d  = lowest_idx(hit);
            end
            if (!mode_q) begin
               if (hit != '0) state_d = (active_d != '0) ? S_KILL : S_REPORT;
            end else if (active_d == '0) begin
               state_d = S_REPORT;
            end
`ifdef RACE_TIMEOUT_EN
            cnt_d = CNT_W'(cnt_q + 1'b1);
            // Watchdog only fires if the normal transitions left us in RUN.
            if (state_d == S_RUN && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               to_d    = 1'b1;
               state_d = S_KILL;
            end
`endif
         end

         S_KILL: begin
            // A completion pulse wins over a simultaneous idle on the same engine.
            idle_hit = eng_idle & active_q & ~hit;
            fin_d    = finished_mask | hit;
            kil_d    = killed_mask | idle_hit;
            active_d = active_q & ~hit & ~idle_hit;
            if (active_d == '0) state_d = S_REPORT;
         end

         S_REPORT: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d  = S_IDLE;
            active_d = '0;
         end
      endcase

      busy_d      = (state_d != S_IDLE);
      eng_start_d = (state_d == S_LAUNCH) ? '1 : '0;
      eng_kill_d  = (state_d == S_KILL) ? active_d : '0;
      done_d      = (state_d == S_REPORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         active_q      <= '0;
         mode_q        <= 1'b0;
         seen_q        <= 1'b0;
         busy          <= 1'b0;
         eng_start     <= '0;
         eng_kill      <= '0;
         done          <= 1'b0;
         winner        <= '0;
         finished_mask <= '0;
         killed_mask   <= '0;
      end else begin
         state_q       <= state_d;
         active_q      <= active_d;
         mode_q        <= mode_d;
         seen_q        <= seen_d;
         busy          <= busy_d;
         eng_start     <= eng_start_d;
         eng_kill      <= eng_kill_d;
         done          <= done_d;
         winner        <= win_d;
         finished_mask <= fin_d;
         killed_mask   <= kil_d;
      end
   end

`ifdef RACE_TIMEOUT_EN
   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end
`else
   logic unused_to;
   assign unused_to = to_d;
`endif

endmodule

// File: tb/tb_race_kill_ctrl.sv
// Directed bench for race_kill_ctrl (N=3); define RACE_TIMEOUT_EN to also exercise the watchdog.
module tb_race_kill_ctrl;
   localparam int unsigned N      = 3;
   localparam int unsigned TO_CYC = 40;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         mode;
   logic         busy;
   logic [N-1:0] eng_start;
   logic [N-1:0] eng_done;
   logic [N-1:0] eng_kill;
   logic [N-1:0] eng_idle;
   logic         done;
   logic [1:0]   winner;
   logic [N-1:0] finished_mask;
   logic [N-1:0] killed_mask;
   logic         timeout;

   int checks   = 0;
   int failures = 0;
   int kill_cycles = 0;
   int done_cycles = 0;
   int k0, d0;

   race_kill_ctrl #(.N(N), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy),
      .eng_start(eng_start), .eng_done(eng_done), .eng_kill(eng_kill),
      .eng_idle(eng_idle), .done(done), .winner(winner),
      .finished_mask(finished_mask), .killed_mask(killed_mask), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (eng_kill != '0) kill_cycles++;
      if (done) done_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic m);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      mode  = 1'b0;
      check("launch_eng_start", 32'(eng_start), 32'h7);
      check("launch_busy", 32'(busy), 32'h1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; eng_done = '0; eng_idle = '0;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_outputs", {eng_start, eng_kill, done, winner, finished_mask, killed_mask, timeout}, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: join-any, engines 0,1 tie, engine 2 killed
      d0 = done_cycles;
      launch(1'b0);
      tick();
      check("s1_run_eng_start", 32'(eng_start), 32'h0);
      repeat (8) tick();
      eng_done = 3'b011;
      tick();
      eng_done = '0;
      check("s1_eng_kill", 32'(eng_kill), 32'h4);
      check("s1_winner", 32'(winner), 32'h0);
      check("s1_finished", 32'(finished_mask), 32'h3);
      tick(); tick();
      check("s1_kill_held", 32'(eng_kill), 32'h4);
      eng_idle = 3'b100;
      tick();
      eng_idle = '0;
      check("s1_done", 32'(done), 32'h1);
      check("s1_killed", 32'(killed_mask), 32'h4);
      check("s1_kill_drop", 32'(eng_kill), 32'h0);
      tick();
      check("s1_idle_busy", 32'(busy), 32'h0);
      check("s1_done_once", 32'(done_cycles - d0), 32'h1);
      check("s1_hold_finished", 32'(finished_mask), 32'h3);

      // 2: join-any, engine 2 wins, 0 and 1 killed after 2 kill cycles
      k0 = kill_cycles;
      launch(1'b0);
      repeat (4) tick();
      eng_done = 3'b100;
      tick();
      eng_done = '0;
      check("s2_winner", 32'(winner), 32'h2);
      check("s2_eng_kill", 32'(eng_kill), 32'h3);
      tick();
      check("s2_eng_kill2", 32'(eng_kill), 32'h3);
      eng_idle = 3'b011;
      tick();
      eng_idle = '0;
      check("s2_done", 32'(done), 32'h1);
      check("s2_masks", {finished_mask, killed_mask}, {3'b100, 3'b011});
      check("s2_kill_cycles", 32'(kill_cycles - k0), 32'h2);
      tick();

      // 3: join-all, done at 10,10,30
      k0 = kill_cycles;
      launch(1'b1);
      repeat (9) tick();
      eng_done = 3'b011;
      tick();
      eng_done = '0;
      check("s3_partial", {busy, done, finished_mask}, {1'b1, 1'b0, 3'b011});
      repeat (19) tick();
      check("s3_not_done", 32'(done), 32'h0);
      eng_done = 3'b100;
      tick();
      eng_done = '0;
      check("s3_done", 32'(done), 32'h1);
      check("s3_winner", 32'(winner), 32'h0);
      check("s3_masks", {finished_mask, killed_mask}, {3'b111, 3'b000});
      check("s3_no_kill", 32'(kill_cycles - k0), 32'h0);
      tick();

      // 4: completion beats a simultaneous idle in the first KILL cycle
      launch(1'b0);
      repeat (2) tick();
      eng_done = 3'b010;
      tick();
      check("s4_winner", 32'(winner), 32'h1);
      check("s4_eng_kill", 32'(eng_kill), 32'h5);
      eng_done = 3'b001;
      eng_idle = 3'b001;
      tick();
      check("s4_race", {finished_mask, killed_mask, eng_kill}, {3'b011, 3'b000, 3'b100});
      eng_done = '0;
      eng_idle = 3'b100;
      tick();
      eng_idle = '0;
      check("s4_done", {done, finished_mask, killed_mask}, {1'b1, 3'b011, 3'b100});
      tick();

      // 5: start in RUN ignored, reset during KILL, then minimum job
      launch(1'b0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("s5_start_ignored", 32'(eng_start), 32'h0);
      eng_done = 3'b001;
      tick();
      eng_done = '0;
      check("s5_in_kill", 32'(eng_kill), 32'h6);
      rst_n = 1'b0;
      #1;
      check("s5_async_rst", {busy, eng_start, eng_kill, done, winner, finished_mask, killed_mask, timeout}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("s5_post_rst_idle", {busy, eng_start, done}, 32'h0);
      launch(1'b0);
      tick();
      eng_done = 3'b111;
      tick();
      eng_done = '0;
      check("s5_min_job", {done, busy, winner, finished_mask, killed_mask}, {1'b1, 1'b1, 2'd0, 3'b111, 3'b000});
      tick();
      check("s5_min_idle", 32'(busy), 32'h0);

`ifdef RACE_TIMEOUT_EN
      // 6: watchdog expires with nothing finished
      launch(1'b0);
      tick();
      repeat (TO_CYC - 1) tick();
      check("s6_pre_timeout", {timeout, eng_kill}, 32'h0);
      tick();
      check("s6_timeout", {timeout, eng_kill}, {1'b1, 3'b111});
      eng_idle = 3'b111;
      tick();
      eng_idle = '0;
      check("s6_done", {done, winner, finished_mask, killed_mask, timeout}, {1'b1, 2'd0, 3'b000, 3'b111, 1'b1});
      tick();
`else
      // 6: without the watchdog RUN waits indefinitely
      launch(1'b0);
      repeat (TO_CYC + 20) tick();
      check("s6_still_run", {busy, timeout, eng_kill, done}, {1'b1, 1'b0, 3'b000, 1'b0});
      eng_done = 3'b111;
      tick();
      eng_done = '0;
      check("s6_done", {done, finished_mask, timeout}, {1'b1, 3'b111, 1'b0});
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end
endmodule
